// File: rtl/ddr3_app_sequencer.sv
// ---------------------------------------------------------------------------
// ddr3_app_sequencer
//
// Purpose:
//   Single-outstanding-transaction bridge between the MCU request port and
//   the MIG 7-series DDR3 application interface, running in the MIG ui_clk
//   domain. A read or write request is accepted over a valid/ready
//   handshake. The block then drives app_en/app_cmd/app_addr and, for
//   writes, one app_wdf beat. It reports completion with one-cycle pulses.
//   Reads are guarded by a watchdog that aborts after RD_TIMEOUT cycles
//   without returned data.
//
// Ports:
//   clk_166M66            MIG ui_clk, the only clock
//   mcu_sys_rst_n         synchronous active-low reset
//   i_init_calib_complete MIG calibration done; gates new requests only
//   i_req_valid / o_req_ready   MCU request handshake
//   i_rw                  1 = write, 0 = read
//   i_address_bus         request address (low 3 bits ignored, BL8 aligned)
//   i_wr_data / i_wr_mask write beat and byte mask (1 = byte not written)
//   o_rd_data / o_rd_valid      read data and its one-cycle valid pulse
//   o_wr_done             pulse: write command and data both accepted
//   o_err                 pulse: read timeout or unexpected read data
//   o_app_*               MIG application interface outputs
//   i_app_rdy, i_app_wdf_rdy, i_app_rd_data, i_app_rd_data_valid
//                         MIG application interface inputs
// ---------------------------------------------------------------------------
module ddr3_app_sequencer #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16,
    parameter int RD_TIMEOUT = 1023
) (
    input  logic                  clk_166M66,
    input  logic                  mcu_sys_rst_n,
    input  logic                  i_init_calib_complete,

    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_rw,
    input  logic [ADDR_WIDTH-1:0] i_address_bus,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [MASK_WIDTH-1:0] i_wr_mask,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_wr_done,
    output logic                  o_err,

    output logic [ADDR_WIDTH-1:0] o_app_addr,
    output logic [2:0]            o_app_cmd,
    output logic                  o_app_en,
    input  logic                  i_app_rdy,
    output logic [DATA_WIDTH-1:0] o_app_wdf_data,
    output logic [MASK_WIDTH-1:0] o_app_wdf_mask,
    output logic                  o_app_wdf_wren,
    output logic                  o_app_wdf_end,
    input  logic                  i_app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0] i_app_rd_data,
    input  logic                  i_app_rd_data_valid
);

    localparam int CNT_WIDTH = $clog2(RD_TIMEOUT + 1);

    // The watchdog fires on the edge where the count would reach RD_TIMEOUT,
    // so the block spends exactly RD_TIMEOUT cycles in RD_WAIT before abort.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RD_TIMEOUT - 1);

    // Clears the three column bits below the BL8 burst boundary.
    localparam logic [ADDR_WIDTH-1:0] ADDR_ALIGN = ~ADDR_WIDTH'(7);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_CMD,
        RD_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_req_ready;
    logic                  r_app_en;
    logic                  r_wdf_wren;
    logic                  r_wr_done;
    logic                  r_rd_valid;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [ADDR_WIDTH-1:0] r_app_addr;
    logic [2:0]            r_app_cmd;
    logic [DATA_WIDTH-1:0] r_wdf_data;
    logic [MASK_WIDTH-1:0] r_wdf_mask;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_accept;
    logic                  w_en_pending;
    logic                  w_wren_pending;
    logic                  w_req_ready_next;
    logic                  w_app_en_next;
    logic                  w_wdf_wren_next;
    logic                  w_wr_done_next;
    logic                  w_rd_valid_next;
    logic                  w_timeout;
    logic                  w_err_next;
    logic                  w_capture;
    logic [CNT_WIDTH-1:0]  w_cnt_next;

    assign w_accept = i_req_valid & r_req_ready;

    // A write strobe is still outstanding after this edge unless its own
    // ready is seen now; the two strobes retire independently.
    assign w_en_pending   = r_app_en   & ~i_app_rdy;
    assign w_wren_pending = r_wdf_wren & ~i_app_wdf_rdy;

    always_comb begin
        w_next_state    = r_state;
        w_app_en_next   = r_app_en;
        w_wdf_wren_next = r_wdf_wren;
        w_wr_done_next  = 1'b0;
        w_rd_valid_next = 1'b0;
        w_timeout       = 1'b0;
        w_capture       = 1'b0;
        w_cnt_next      = r_cnt;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state    = i_rw ? WRITE : READ_CMD;
                    w_app_en_next   = 1'b1;
                    w_wdf_wren_next = i_rw;
                end
            end

            WRITE: begin
                w_app_en_next   = w_en_pending;
                w_wdf_wren_next = w_wren_pending;
                if (!w_en_pending && !w_wren_pending) begin
                    w_wr_done_next = 1'b1;
                    w_next_state   = IDLE;
                end
            end

            READ_CMD: begin
                if (i_app_rdy) begin
                    w_app_en_next = 1'b0;
                    w_cnt_next    = '0;
                    w_next_state  = RD_WAIT;
                end
            end

            RD_WAIT: begin
                // Returned data takes priority over an expiring watchdog.
                if (i_app_rd_data_valid) begin
                    w_capture       = 1'b1;
                    w_rd_valid_next = 1'b1;
                    w_next_state    = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_WIDTH'(1);
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Read data with no read outstanding is dropped and flagged.
        w_err_next = w_timeout | (i_app_rd_data_valid & (r_state != RD_WAIT));

        // Ready is registered, so it is derived from where the FSM will be.
        w_req_ready_next = (w_next_state == IDLE) & i_init_calib_complete;
    end

    always_ff @(posedge clk_166M66) begin
        if (!mcu_sys_rst_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_app_en    <= 1'b0;
            r_wdf_wren  <= 1'b0;
            r_wr_done   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_next_state;
            r_req_ready <= w_req_ready_next;
            r_app_en    <= w_app_en_next;
            r_wdf_wren  <= w_wdf_wren_next;
            r_wr_done   <= w_wr_done_next;
            r_rd_valid  <= w_rd_valid_next;
            r_err       <= w_err_next;
            r_cnt       <= w_cnt_next;
        end
    end

    // Request fields are captured only in the accept cycle; the MCU may
    // change them freely afterwards.
    always_ff @(posedge clk_166M66) begin
        if (!mcu_sys_rst_n) begin
            r_app_addr <= '0;
            r_app_cmd  <= 3'b000;
            r_wdf_data <= '0;
            r_wdf_mask <= '0;
            r_rd_data  <= '0;
        end else begin
            if (w_accept) begin
                r_app_addr <= i_address_bus & ADDR_ALIGN;
                r_app_cmd  <= {2'b00, ~i_rw};
                r_wdf_data <= i_wr_data;
                r_wdf_mask <= i_wr_mask;
            end
            if (w_capture) begin
                r_rd_data <= i_app_rd_data;
            end
        end
    end

    assign o_req_ready    = r_req_ready;
    assign o_rd_data      = r_rd_data;
    assign o_rd_valid     = r_rd_valid;
    assign o_wr_done      = r_wr_done;
    assign o_err          = r_err;
    assign o_app_addr     = r_app_addr;
    assign o_app_cmd      = r_app_cmd;
    assign o_app_en       = r_app_en;
    assign o_app_wdf_data = r_wdf_data;
    assign o_app_wdf_mask = r_wdf_mask;
    assign o_app_wdf_wren = r_wdf_wren;
    // Every write is a single beat, so the last-beat marker tracks wren.
    assign o_app_wdf_end  = r_wdf_wren;

endmodule

// File: tb/tb_ddr3_app_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ddr3_app_sequencer
//
// Directed testbench for ddr3_app_sequencer. Expected values are written out
// by hand per cycle relative to the accept edge. The MIG side is emulated by
// driving app_rdy / app_wdf_rdy / app_rd_data_valid on chosen cycles.
// ---------------------------------------------------------------------------
module tb_ddr3_app_sequencer;

    localparam int ADDR_WIDTH = 28;
    localparam int DATA_WIDTH = 128;
    localparam int MASK_WIDTH = 16;
    localparam int RD_TIMEOUT = 15;

    logic                  clk_166M66 = 1'b0;
    logic                  mcu_sys_rst_n;
    logic                  i_init_calib_complete;
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_rw;
    logic [ADDR_WIDTH-1:0] i_address_bus;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic [MASK_WIDTH-1:0] i_wr_mask;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_rd_valid;
    logic                  o_wr_done;
    logic                  o_err;
    logic [ADDR_WIDTH-1:0] o_app_addr;
    logic [2:0]            o_app_cmd;
    logic                  o_app_en;
    logic                  i_app_rdy;
    logic [DATA_WIDTH-1:0] o_app_wdf_data;
    logic [MASK_WIDTH-1:0] o_app_wdf_mask;
    logic                  o_app_wdf_wren;
    logic                  o_app_wdf_end;
    logic                  i_app_wdf_rdy;
    logic [DATA_WIDTH-1:0] i_app_rd_data;
    logic                  i_app_rd_data_valid;

    int                    vectorCount = 0;
    int                    missCount   = 0;
    logic [DATA_WIDTH-1:0] lastRdData;

    always #3 clk_166M66 = ~clk_166M66;

    ddr3_app_sequencer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MASK_WIDTH (MASK_WIDTH),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .clk_166M66            (clk_166M66),
        .mcu_sys_rst_n         (mcu_sys_rst_n),
        .i_init_calib_complete (i_init_calib_complete),
        .i_req_valid           (i_req_valid),
        .o_req_ready           (o_req_ready),
        .i_rw                  (i_rw),
        .i_address_bus         (i_address_bus),
        .i_wr_data             (i_wr_data),
        .i_wr_mask             (i_wr_mask),
        .o_rd_data             (o_rd_data),
        .o_rd_valid            (o_rd_valid),
        .o_wr_done             (o_wr_done),
        .o_err                 (o_err),
        .o_app_addr            (o_app_addr),
        .o_app_cmd             (o_app_cmd),
        .o_app_en              (o_app_en),
        .i_app_rdy             (i_app_rdy),
        .o_app_wdf_data        (o_app_wdf_data),
        .o_app_wdf_mask        (o_app_wdf_mask),
        .o_app_wdf_wren        (o_app_wdf_wren),
        .o_app_wdf_end         (o_app_wdf_end),
        .i_app_wdf_rdy         (i_app_wdf_rdy),
        .i_app_rd_data         (i_app_rd_data),
        .i_app_rd_data_valid   (i_app_rd_data_valid)
    );

    function automatic logic [DATA_WIDTH-1:0] randomWide();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Outputs are all registered, so sampling 1 time unit after the edge
    // sees the settled post-edge values.
    task automatic tick();
        @(posedge clk_166M66);
        #1;
    endtask

    task automatic applyStimulus(input logic rw, input logic [ADDR_WIDTH-1:0] addr,
                                 input logic [DATA_WIDTH-1:0] data,
                                 input logic [MASK_WIDTH-1:0] mask);
        i_req_valid   = 1'b1;
        i_rw          = rw;
        i_address_bus = addr;
        i_wr_data     = data;
        i_wr_mask     = mask;
    endtask

    task automatic dropRequest();
        i_req_valid   = 1'b0;
        i_rw          = 1'($urandom());
        i_address_bus = ADDR_WIDTH'($urandom());
        i_wr_data     = randomWide();
        i_wr_mask     = MASK_WIDTH'($urandom());
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "/ctrl"}, 128'({o_req_ready, o_rd_valid, o_wr_done, o_err, o_app_en,
                                          o_app_wdf_wren, o_app_wdf_end, o_app_cmd}), 128'(0));
        checkOutput({tag, "/rd_data"}, o_rd_data, 128'(0));
        checkOutput({tag, "/app_addr"}, 128'(o_app_addr), 128'(0));
        checkOutput({tag, "/wdf_data"}, o_app_wdf_data, 128'(0));
        checkOutput({tag, "/wdf_mask"}, 128'(o_app_wdf_mask), 128'(0));
    endtask

    // enCycles / wrenCycles: number of cycles each strobe stays high, i.e.
    // the index of the edge after accept at which its ready is seen.
    task automatic writeTransaction(input string tag, input logic [ADDR_WIDTH-1:0] addr,
                                    input logic [ADDR_WIDTH-1:0] expAddr,
                                    input logic [DATA_WIDTH-1:0] data,
                                    input logic [MASK_WIDTH-1:0] mask,
                                    input int enCycles, input int wrenCycles);
        int last;
        last = (enCycles > wrenCycles) ? enCycles : wrenCycles;
        i_app_rdy     = 1'b0;
        i_app_wdf_rdy = 1'b0;
        checkOutput({tag, "/ready_pre"}, 128'(o_req_ready), 128'(1));
        applyStimulus(1'b1, addr, data, mask);
        tick();
        dropRequest();
        for (int k = 0; k <= last; k++) begin
            if (k == 0) begin
                checkOutput({tag, "/addr"}, 128'(o_app_addr), 128'(expAddr));
                checkOutput({tag, "/cmd"}, 128'(o_app_cmd), 128'(3'b000));
                checkOutput({tag, "/wdf_data"}, o_app_wdf_data, data);
                checkOutput({tag, "/wdf_mask"}, 128'(o_app_wdf_mask), 128'(mask));
            end
            checkOutput($sformatf("%s/en@%0d", tag, k), 128'(o_app_en), 128'(k < enCycles));
            checkOutput($sformatf("%s/wren@%0d", tag, k), 128'(o_app_wdf_wren), 128'(k < wrenCycles));
            checkOutput($sformatf("%s/end@%0d", tag, k), 128'(o_app_wdf_end), 128'(k < wrenCycles));
            checkOutput($sformatf("%s/done@%0d", tag, k), 128'(o_wr_done), 128'(k == last));
            checkOutput($sformatf("%s/ready@%0d", tag, k), 128'(o_req_ready), 128'(k == last));
            i_app_rdy     = (k >= enCycles - 1);
            i_app_wdf_rdy = (k >= wrenCycles - 1);
            tick();
        end
        checkOutput({tag, "/done_end"}, 128'(o_wr_done), 128'(0));
        checkOutput({tag, "/en_end"}, 128'({o_app_en, o_app_wdf_wren}), 128'(0));
        i_app_rdy     = 1'b0;
        i_app_wdf_rdy = 1'b0;
    endtask

    // cmdCycles: cycles app_en stays high. validAt: data returns on the edge
    // validAt cycles after the command handshake; 0 means never (timeout).
    task automatic readTransaction(input string tag, input logic [ADDR_WIDTH-1:0] addr,
                                   input logic [ADDR_WIDTH-1:0] expAddr,
                                   input int cmdCycles, input int validAt,
                                   input logic [DATA_WIDTH-1:0] rdData);
        int last;
        last = (validAt > 0) ? cmdCycles + validAt : cmdCycles + RD_TIMEOUT;
        i_app_rdy = 1'b0;
        checkOutput({tag, "/ready_pre"}, 128'(o_req_ready), 128'(1));
        applyStimulus(1'b0, addr, randomWide(), MASK_WIDTH'($urandom()));
        tick();
        dropRequest();
        for (int k = 0; k <= last; k++) begin
            if (k == 0) begin
                checkOutput({tag, "/addr"}, 128'(o_app_addr), 128'(expAddr));
                checkOutput({tag, "/cmd"}, 128'(o_app_cmd), 128'(3'b001));
            end
            checkOutput($sformatf("%s/en@%0d", tag, k), 128'(o_app_en), 128'(k < cmdCycles));
            checkOutput($sformatf("%s/wren@%0d", tag, k), 128'(o_app_wdf_wren), 128'(0));
            checkOutput($sformatf("%s/rd_valid@%0d", tag, k), 128'(o_rd_valid),
                        128'(validAt > 0 && k == last));
            checkOutput($sformatf("%s/err@%0d", tag, k), 128'(o_err),
                        128'(validAt == 0 && k == last));
            checkOutput($sformatf("%s/ready@%0d", tag, k), 128'(o_req_ready), 128'(k == last));
            if (k == last) begin
                if (validAt > 0) begin
                    lastRdData = rdData;
                end
                checkOutput({tag, "/rd_data"}, o_rd_data, lastRdData);
            end
            i_app_rdy           = (k >= cmdCycles - 1);
            i_app_rd_data_valid = (validAt > 0 && k == cmdCycles + validAt - 1);
            i_app_rd_data       = i_app_rd_data_valid ? rdData : randomWide();
            tick();
        end
        i_app_rd_data_valid = 1'b0;
        i_app_rdy           = 1'b0;
        checkOutput({tag, "/pulse_end"}, 128'({o_rd_valid, o_err}), 128'(0));
        checkOutput({tag, "/rd_data_hold"}, o_rd_data, lastRdData);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        lastRdData          = '0;
        mcu_sys_rst_n       = 1'b0;
        i_init_calib_complete = 1'b0;
        i_req_valid         = 1'b0;
        i_rw                = 1'b0;
        i_address_bus       = '0;
        i_wr_data           = '0;
        i_wr_mask           = '0;
        i_app_rdy           = 1'b0;
        i_app_wdf_rdy       = 1'b0;
        i_app_rd_data       = '0;
        i_app_rd_data_valid = 1'b0;

        $display("[TB] reset with random inputs");
        for (int i = 0; i < 5; i++) begin
            i_init_calib_complete = 1'($urandom());
            i_req_valid           = 1'($urandom());
            i_rw                  = 1'($urandom());
            i_address_bus         = ADDR_WIDTH'($urandom());
            i_wr_data             = randomWide();
            i_wr_mask             = MASK_WIDTH'($urandom());
            i_app_rdy             = 1'($urandom());
            i_app_wdf_rdy         = 1'($urandom());
            i_app_rd_data         = randomWide();
            i_app_rd_data_valid   = 1'($urandom());
            tick();
            checkAllZero($sformatf("reset%0d", i));
        end

        i_init_calib_complete = 1'b0;
        i_req_valid           = 1'b0;
        i_app_rdy             = 1'b0;
        i_app_wdf_rdy         = 1'b0;
        i_app_rd_data_valid   = 1'b0;
        mcu_sys_rst_n         = 1'b1;
        tick();
        checkOutput("ready_no_calib0", 128'(o_req_ready), 128'(0));
        tick();
        checkOutput("ready_no_calib1", 128'(o_req_ready), 128'(0));
        i_init_calib_complete = 1'b1;
        tick();
        checkOutput("ready_after_calib", 128'(o_req_ready), 128'(1));

        $display("[TB] writes");
        writeTransaction("wr_fast", 28'h000000F, 28'h0000008,
                         128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 16'h0000, 1, 1);
        writeTransaction("wr_stall", 28'h0ABC123, 28'h0ABC120,
                         128'h11112222_33334444_55556666_77778888, 16'h00F0, 4, 7);
        writeTransaction("wr_data_first", 28'hFFFFFFF, 28'hFFFFFF8,
                         128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0, 16'hA5A5, 5, 2);
        writeTransaction("wr_same_late", 28'h0000004, 28'h0000000,
                         128'h0, 16'hFFFF, 3, 3);

        $display("[TB] reads");
        readTransaction("rd_normal", 28'h0123450, 28'h0123450, 3, 12,
                        128'h0123456789ABCDEF0123456789ABCDEF);
        readTransaction("rd_timeout", 28'hABCDEF7, 28'hABCDEF0, 1, 0, 128'h0);
        readTransaction("rd_valid_at_timeout", 28'h7654329, 28'h7654328, 2, RD_TIMEOUT,
                        128'hFEDCBA98_76543210_A5A5A5A5_5A5A5A5A);

        $display("[TB] stray read data in IDLE");
        i_app_rd_data       = 128'h99999999_99999999_99999999_99999999;
        i_app_rd_data_valid = 1'b1;
        tick();
        i_app_rd_data_valid = 1'b0;
        checkOutput("stray/err", 128'(o_err), 128'(1));
        checkOutput("stray/ready", 128'(o_req_ready), 128'(1));
        checkOutput("stray/rd_valid", 128'(o_rd_valid), 128'(0));
        checkOutput("stray/rd_data", o_rd_data, lastRdData);
        tick();
        checkOutput("stray/err_once", 128'(o_err), 128'(0));
        checkOutput("stray/ready_after", 128'(o_req_ready), 128'(1));

        $display("[TB] reset during RD_WAIT");
        applyStimulus(1'b0, 28'h0000100, randomWide(), 16'h0);
        tick();
        dropRequest();
        checkOutput("rstwait/en", 128'(o_app_en), 128'(1));
        i_app_rdy = 1'b1;
        tick();
        i_app_rdy = 1'b0;
        checkOutput("rstwait/en_off", 128'(o_app_en), 128'(0));
        tick();
        tick();
        mcu_sys_rst_n = 1'b0;
        tick();
        checkAllZero("rstwait");
        mcu_sys_rst_n = 1'b1;
        for (int k = 0; k <= RD_TIMEOUT + 2; k++) begin
            tick();
            checkOutput($sformatf("rstwait/pulses@%0d", k), 128'({o_rd_valid, o_err, o_wr_done}),
                        128'(0));
            checkOutput($sformatf("rstwait/ready@%0d", k), 128'(o_req_ready), 128'(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
